conva1_ifm_feeder: RTL and testbench

CONVA1_IFM_FEEDER -- requirements
Module: conva1_ifm_feeder

---
 rtl/conva1_ifm_feeder.sv | 142 ++++++++++++++
 tb/tb_conva1_ifm_feeder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/conva1_ifm_feeder.sv
// conva1_ifm_feeder: streams IFM pixels from memory into a conv unit FIFO and tracks window/OFM timing
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   start                        begin one run when idle
//   ifm_stall                    pause read issue (only with CONVA1_FEEDER_STALL_EN defined)
//   ifm_enable_read/ifm_address  IFM memory read strobe and address
//   ifm_data_out                 IFM read data, valid one cycle after the strobe
//   unit_data_in/fifo_enable     pixel and push strobe toward the conv unit FIFO
//   conv_enable                  FIFO holds a complete window
//   ofm_valid/ofm_address/ofm_channel  conv result valid, its OFM index and input channel
//   busy, done                   run in progress, one-cycle end-of-run pulse
// Macro CONVA1_FEEDER_STALL_EN enables ifm_stall; otherwise the stall input is ignored.
module conva1_ifm_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 15,
    parameter int IFM_SIZE     = 32,
    parameter int IFM_DEPTH    = 3,
    parameter int KERNAL_SIZE  = 5,
    parameter int CONV_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ifm_stall,
    output logic                    ifm_enable_read,
    output logic [ADDRESS_BITS-1:0] ifm_address,
    input  logic [DATA_WIDTH-1:0]   ifm_data_out,
    output logic [DATA_WIDTH-1:0]   unit_data_in,
    output logic                    fifo_enable,
    output logic                    conv_enable,
    output logic                    ofm_valid,
    output logic [$clog2((IFM_SIZE-KERNAL_SIZE+1)**2)-1:0] ofm_address,
    output logic [$clog2(IFM_DEPTH):0] ofm_channel,
    output logic                    busy,
    output logic                    done
);
    localparam int OW  = IFM_SIZE - KERNAL_SIZE + 1;
    localparam int OAW = $clog2(OW * OW);
    localparam int CHW = $clog2(IFM_DEPTH) + 1;
    localparam int PW  = $clog2(IFM_SIZE);
    localparam int L   = CONV_LATENCY;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           col_q, col_d, row_q, row_d, pcol_q, pcol_d, prow_q, prow_d;
    logic [CHW-1:0]          ch_q, ch_d, pch_q, pch_d, cch_q, cch_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                    push_q, push_d, conv_q, conv_d;
    logic [OAW-1:0]          caddr_q, caddr_d;
    logic [L-1:0]            dv_q, dv_d;
    logic [OAW-1:0]          da_q [L];
    logic [OAW-1:0]          da_d [L];
    logic [CHW-1:0]          dc_q [L];
    logic [CHW-1:0]          dc_d [L];
    logic                    stall, rd, col_last, row_last, ch_last, last_px, win;

`ifdef CONVA1_FEEDER_STALL_EN
    assign stall = ifm_stall;
`else
    assign stall = ifm_stall & 1'b0;
`endif

    always_comb begin
        rd       = state_q == STREAM && !stall;
        col_last = col_q == PW'(IFM_SIZE - 1);
        row_last = row_q == PW'(IFM_SIZE - 1);
        ch_last  = ch_q == CHW'(IFM_DEPTH - 1);
        last_px  = col_last && row_last && ch_last;
        // Row/column restart every channel; the linear address runs on and wraps to 0 at run end.
        col_d    = rd ? (col_last ? '0 : col_q + PW'(1)) : col_q;
        row_d    = rd && col_last ? (row_last ? '0 : row_q + PW'(1)) : row_q;
        ch_d     = rd && col_last && row_last ? (ch_last ? '0 : ch_q + CHW'(1)) : ch_q;
        addr_d   = rd ? (last_px ? '0 : addr_q + ADDRESS_BITS'(1)) : addr_q;
        push_d   = rd;
        prow_d   = row_q;
        pcol_d   = col_q;
        pch_d    = ch_q;
        win      = push_q && prow_q >= PW'(KERNAL_SIZE - 1) && pcol_q >= PW'(KERNAL_SIZE - 1);
        conv_d   = win;
        caddr_d  = win ? OAW'((32'(prow_q) - 32'(KERNAL_SIZE - 1)) * 32'(OW)
                              + 32'(pcol_q) - 32'(KERNAL_SIZE - 1)) : '0;
        cch_d    = win ? pch_q : '0;
        dv_d     = L'({dv_q, conv_q});
        da_d[0]  = caddr_q;
        dc_d[0]  = cch_q;
        for (int i = 1; i < L; i++) begin
            da_d[i] = da_q[i-1];
            dc_d[i] = dc_q[i-1];
        end
        // The run ends once every issued pixel has left the push/window/latency pipeline.
        done     = state_q == DRAIN && !(push_q || conv_q || |dv_q);
        state_d  = state_q == IDLE   ? (start ? STREAM : IDLE) :
                   state_q == STREAM ? (rd && last_px ? DRAIN : STREAM) :
                                       (done ? IDLE : DRAIN);
        busy            = state_q != IDLE;
        ifm_enable_read = rd;
        ifm_address     = addr_q;
        unit_data_in    = ifm_data_out;
        fifo_enable     = push_q;
        conv_enable     = conv_q;
        ofm_valid       = dv_q[L-1];
        ofm_address     = da_q[L-1];
        ofm_channel     = dc_q[L-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            push_q  <= 1'b0;
            prow_q  <= '0;
            pcol_q  <= '0;
            pch_q   <= '0;
            conv_q  <= 1'b0;
            caddr_q <= '0;
            cch_q   <= '0;
            dv_q    <= '0;
            da_q    <= '{default: '0};
            dc_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            push_q  <= push_d;
            prow_q  <= prow_d;
            pcol_q  <= pcol_d;
            pch_q   <= pch_d;
            conv_q  <= conv_d;
            caddr_q <= caddr_d;
            cch_q   <= cch_d;
            dv_q    <= dv_d;
            da_q    <= da_d;
            dc_q    <= dc_d;
        end
    end
endmodule

// File: tb/tb_conva1_ifm_feeder.sv
// tb_conva1_ifm_feeder: randomized bench for conva1_ifm_feeder against a pixel-index reference model
module tb_conva1_ifm_feeder;
    localparam int DW = 32, AB = 15, S = 32, D = 3, K = 5, L = 1;
    localparam int N = D * S * S, OW = S - K + 1;
`ifdef CONVA1_FEEDER_STALL_EN
    localparam int SH = 10;
`else
    localparam int SH = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, ifm_stall;
    logic          ifm_enable_read, fifo_enable, conv_enable, ofm_valid, busy, done;
    logic [AB-1:0] ifm_address;
    logic [DW-1:0] ifm_data_out, unit_data_in;
    logic [9:0]    ofm_address;
    logic [2:0]    ofm_channel;

    always #5 clk = ~clk;

    conva1_ifm_feeder dut (
        .clk(clk), .reset(reset), .start(start), .ifm_stall(ifm_stall),
        .ifm_enable_read(ifm_enable_read), .ifm_address(ifm_address),
        .ifm_data_out(ifm_data_out), .unit_data_in(unit_data_in),
        .fifo_enable(fifo_enable), .conv_enable(conv_enable), .ofm_valid(ofm_valid),
        .ofm_address(ofm_address), .ofm_channel(ofm_channel), .busy(busy), .done(done)
    );

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix(input int a);
        return 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
    endfunction

    // reference model: pixels are identified by their linear index in the run
    int cyc = 0, t0 = 0;
    bit m_busy = 0, m_stream = 0;
    int m_k = 0, m_prev_rd = -1, m_prev_push = -1, done_due = -1;
    int q_due[$], q_addr[$], q_ch[$];
    bit q_last[$];
    bit mem_rd = 0;
    int mem_addr = 0;
    int first_rd, fr_addr, first_push, first_conv, first_ofm, fo_addr, fo_ch;
    int last_ofm, lo_addr, lo_ch, done_cyc, n_rd, n_conv, n_done;

    task automatic step(input bit st, input bit stl, input bit rs);
        bit eff, erd, epush, econv, eofm, edone, was_busy;
        int r, c, ch, rel;
        @(posedge clk);
        #1;
        ifm_data_out = mem_rd ? pix(mem_addr) : $urandom;
        start = st;
        ifm_stall = stl;
        reset = rs;
        @(negedge clk);
`ifdef CONVA1_FEEDER_STALL_EN
        eff = stl;
`else
        eff = 1'b0;
`endif
        erd = m_stream && !eff;
        check("rd", ifm_enable_read, erd);
        if (erd) check("rd_addr", ifm_address, m_k);
        epush = m_prev_rd >= 0;
        check("push", fifo_enable, epush);
        if (epush) check("push_data", unit_data_in, pix(m_prev_rd));
        econv = 1'b0;
        if (m_prev_push >= 0) begin
            ch = m_prev_push / (S * S);
            r = (m_prev_push % (S * S)) / S;
            c = m_prev_push % S;
            econv = r >= K - 1 && c >= K - 1;
        end
        check("conv", conv_enable, econv);
        eofm = q_due.size() > 0 && q_due[0] == cyc;
        check("ofm_valid", ofm_valid, eofm);
        if (eofm) begin
            check("ofm_addr", ofm_address, q_addr[0]);
            check("ofm_ch", ofm_channel, q_ch[0]);
        end
        edone = cyc == done_due;
        check("done", done, edone);
        check("busy", busy, m_busy);
        rel = cyc - t0;
        if (ifm_enable_read) begin
            n_rd++;
            if (first_rd < 0) begin first_rd = rel; fr_addr = ifm_address; end
        end
        if (fifo_enable && first_push < 0) first_push = rel;
        if (conv_enable) begin n_conv++; if (first_conv < 0) first_conv = rel; end
        if (ofm_valid) begin
            if (first_ofm < 0) begin first_ofm = rel; fo_addr = ofm_address; fo_ch = ofm_channel; end
            last_ofm = rel; lo_addr = ofm_address; lo_ch = ofm_channel;
        end
        if (done) begin n_done++; done_cyc = rel; end
        mem_rd = ifm_enable_read;
        mem_addr = ifm_address;
        if (rs) begin
            m_busy = 0; m_stream = 0; m_prev_rd = -1; m_prev_push = -1; done_due = -1;
            q_due.delete(); q_addr.delete(); q_ch.delete(); q_last.delete();
        end else begin
            was_busy = m_busy;
            if (econv) begin
                q_due.push_back(cyc + L);
                q_addr.push_back((r - K + 1) * OW + c - K + 1);
                q_ch.push_back(ch);
                q_last.push_back(m_prev_push == N - 1);
            end
            if (eofm) begin
                if (q_last[0]) done_due = cyc + 1;
                void'(q_due.pop_front()); void'(q_addr.pop_front());
                void'(q_ch.pop_front()); void'(q_last.pop_front());
            end
            m_prev_push = m_prev_rd;
            m_prev_rd = erd ? m_k : -1;
            if (erd) begin m_k++; if (m_k == N) m_stream = 0; end
            if (edone) m_busy = 0;
            if (!was_busy && st) begin m_busy = 1; m_stream = 1; m_k = 0; end
        end
        cyc++;
    endtask

    // mode 0: no stall, 1: stall window at 50..59, 2: window plus random stalls
    task automatic run(input int mode, input int rst_at, input int sh);
        bit stl;
        int end_at;
        t0 = cyc;
        first_rd = -1; fr_addr = -1; first_push = -1; first_conv = -1; first_ofm = -1;
        fo_addr = -1; fo_ch = -1; last_ofm = -1; lo_addr = -1; lo_ch = -1; done_cyc = -1;
        n_rd = 0; n_conv = 0; n_done = 0;
        end_at = 3076 + (mode == 1 ? SH : 0);
        step(1, 0, 0);
        for (int i = 1; i < 9000; i++) begin
            stl = (mode != 0 && i >= 50 && i < 60) || (mode == 2 && $urandom_range(0, 7) == 0);
            step(i == 200 || i == end_at, stl, i == rst_at);
            if (i == rst_at || n_done > 0) break;
        end
        if (rst_at > 0) begin
            step(0, 0, 0);
            check("rst_busy", busy, 0);
            check("rst_rd", ifm_enable_read, 0);
            check("rst_addr", ifm_address, 0);
            check("rst_push", fifo_enable, 0);
            check("rst_conv", conv_enable, 0);
            check("rst_ofm", ofm_valid, 0);
            check("rst_ofm_addr", ofm_address, 0);
            check("rst_ofm_ch", ofm_channel, 0);
            check("rst_no_done", n_done, 0);
        end else begin
            check("done_count", n_done, 1);
        end
        if (sh >= 0) begin
            check("first_rd", first_rd, 1);
            check("first_rd_addr", fr_addr, 0);
            check("first_push", first_push, 2);
            check("first_conv", first_conv, 135 + sh);
            check("first_ofm", first_ofm, 136 + sh);
            check("first_ofm_addr", fo_addr, 0);
            check("first_ofm_ch", fo_ch, 0);
            check("n_reads", n_rd, N);
            check("n_conv", n_conv, D * OW * OW);
            check("last_ofm", last_ofm, 3075 + sh);
            check("last_ofm_addr", lo_addr, 783);
            check("last_ofm_ch", lo_ch, 2);
            check("done_cycle", done_cyc, 3076 + sh);
        end
        repeat (3) step(0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ifm_stall = 1'b0;
        ifm_data_out = '0;
        step(0, 0, 1);
        step(0, 0, 0);
        check("reset_addr", ifm_address, 0);
        check("reset_ofm_addr", ofm_address, 0);
        check("reset_ofm_ch", ofm_channel, 0);
        run(0, -1, 0);
        run(1, -1, SH);
        run(2, 500, -1);
        run(0, -1, 0);
        run(2, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
